// File: rtl/dmux_stream.sv
// Registered 1-to-N stream demultiplexer. It holds one word and a mask of channels that still owe a
// handshake. A new word is accepted only once every addressed channel has taken the current one.
module dmux_stream #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 3,
  localparam int N = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_bcast,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [15:0]      in_count
);

  logic [N-1:0]     pend_reg;
  logic [N-1:0]     pend_next;
  logic [N-1:0]     remain;
  logic [N-1:0]     sel_mask;
  logic [WIDTH-1:0] data_reg;
  logic [15:0]      count_reg;
  logic             accept;

  // Decode the target mask. Broadcast forces every bit on.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_sel
      assign sel_mask[gi] = in_bcast | (in_sel == SEL_W'(gi));
    end
  endgenerate

  // Channels that are still pending after this cycle's handshakes. The combinational path from
  // out_ready to in_ready is deliberate: it lets a word be refilled in the same cycle it drains.
  assign remain   = pend_reg & ~out_ready;
  assign in_ready = (remain == '0);
  assign accept   = in_valid & in_ready;

  always_comb begin
    pend_next = remain;
    if (accept) begin
      pend_next = sel_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg  <= '0;
      data_reg  <= '0;
      count_reg <= '0;
    end else begin
      pend_reg <= pend_next;
      if (accept) begin
        data_reg  <= in_data;
        count_reg <= count_reg + 16'd1;
      end
    end
  end

  assign out_valid = pend_reg;
  assign out_data  = data_reg;
  assign busy      = |pend_reg;
  assign in_count  = count_reg;

endmodule

// File: tb/tb_dmux_stream.sv
// Directed bench for dmux_stream. It runs a vector table with routing, stall and broadcast cases,
// then hand-written sequences for an asynchronous reset mid-word and for the counter wrap.
module tb_dmux_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [2:0]  in_sel;
  logic        in_bcast;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [15:0] out_data;
  logic        busy;
  logic [15:0] in_count;

  int tests = 0;
  int fails = 0;
  int hs_cnt [8];
  bit hs_en = 1'b0;

  typedef struct {
    logic        v;
    logic [2:0]  sel;
    logic        bc;
    logic [15:0] data;
    logic [7:0]  ordy;
    logic        rdy;
    logic [7:0]  valid;
    logic [15:0] dout;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  dmux_stream #(.WIDTH(16), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .in_count(in_count)
  );

  always #5 clk = ~clk;

  // Count channel handshakes mid-cycle, while the inputs and out_valid are stable.
  always @(negedge clk) begin
    if (hs_en) begin
      for (int i = 0; i < 8; i++) begin
        if (out_valid[i] && out_ready[i]) hs_cnt[i]++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [2:0] sel, input logic bc,
                              input logic [15:0] data, input logic [7:0] ordy, input logic rdy,
                              input logic [7:0] valid, input logic [15:0] dout,
                              input logic [15:0] cnt);
    vec_t r;
    r.v = v; r.sel = sel; r.bc = bc; r.data = data; r.ordy = ordy;
    r.rdy = rdy; r.valid = valid; r.dout = dout; r.cnt = cnt;
    return r;
  endfunction

  initial begin
    int exp_hs [8];
    exp_hs = '{2, 4, 2, 3, 2, 2, 3, 2};

    // Single route, every consumer ready: one word per cycle.
    for (int s = 0; s < 8; s++) begin
      vecs.push_back(mk(1'b1, 3'(s), 1'b0, 16'hA000 + 16'(s), 8'hFF, 1'b1,
                        8'(1 << s), 16'hA000 + 16'(s), 16'(s + 1)));
    end
    // Stall: channel 3 holds BEEF for 4 cycles while a second word waits.
    vecs.push_back(mk(1'b1, 3'd3, 1'b0, 16'hBEEF, 8'hFF, 1'b1, 8'h08, 16'hBEEF, 16'd9));
    for (int k = 0; k < 4; k++) begin
      vecs.push_back(mk(1'b1, 3'd6, 1'b0, 16'h1111, 8'hF7, 1'b0, 8'h08, 16'hBEEF, 16'd9));
    end
    vecs.push_back(mk(1'b1, 3'd6, 1'b0, 16'h1111, 8'hFF, 1'b1, 8'h40, 16'h1111, 16'd10));
    // Broadcast with partial delivery.
    vecs.push_back(mk(1'b1, 3'd0, 1'b1, 16'h5A5A, 8'hFF, 1'b1, 8'hFF, 16'h5A5A, 16'd11));
    vecs.push_back(mk(1'b0, 3'd0, 1'b0, 16'h0000, 8'h0F, 1'b0, 8'hF0, 16'h5A5A, 16'd11));
    vecs.push_back(mk(1'b0, 3'd0, 1'b0, 16'h0000, 8'hF0, 1'b1, 8'h00, 16'h5A5A, 16'd11));
    vecs.push_back(mk(1'b0, 3'd0, 1'b0, 16'h0000, 8'hFF, 1'b1, 8'h00, 16'h5A5A, 16'd11));
    // Back-to-back to the same channel, then a stall on it.
    vecs.push_back(mk(1'b1, 3'd1, 1'b0, 16'h0101, 8'h00, 1'b1, 8'h02, 16'h0101, 16'd12));
    vecs.push_back(mk(1'b1, 3'd1, 1'b0, 16'h0202, 8'h02, 1'b1, 8'h02, 16'h0202, 16'd13));
    vecs.push_back(mk(1'b0, 3'd1, 1'b0, 16'h0000, 8'hFD, 1'b0, 8'h02, 16'h0202, 16'd13));
    vecs.push_back(mk(1'b0, 3'd1, 1'b0, 16'h0000, 8'h02, 1'b1, 8'h00, 16'h0202, 16'd13));

    for (int i = 0; i < 8; i++) hs_cnt[i] = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; in_bcast = 1'b0; out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(out_valid), 32'h0);
    check("reset_data", 32'(out_data), 32'h0);
    check("reset_count", 32'(in_count), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    #1;
    check("idle_ready", 32'(in_ready), 32'h1);
    hs_en = 1'b1;

    foreach (vecs[i]) begin
      in_valid = vecs[i].v; in_sel = vecs[i].sel; in_bcast = vecs[i].bc;
      in_data = vecs[i].data; out_ready = vecs[i].ordy;
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].valid));
      check($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].dout));
      check($sformatf("v%0d_in_count", i), 32'(in_count), 32'(vecs[i].cnt));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(|vecs[i].valid));
    end
    in_valid = 1'b0; out_ready = '0;
    @(negedge clk);
    hs_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("handshakes_ch%0d", i), 32'(hs_cnt[i]), 32'(exp_hs[i]));
    end

    // Asynchronous reset while a word is held on channel 5.
    @(posedge clk); #1;
    in_valid = 1'b1; in_sel = 3'd5; in_bcast = 1'b0; in_data = 16'h1234; out_ready = 8'h00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hold_valid", 32'(out_valid), 32'h20);
    check("hold_data", 32'(out_data), 32'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_data", 32'(out_data), 32'h0);
    check("async_rst_count", 32'(in_count), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'h1);

    // Counter wrap: 65537 accepts leave the count at 1.
    @(posedge clk); #1;
    in_valid = 1'b1; in_bcast = 1'b0; in_data = 16'hC0DE; out_ready = 8'hFF;
    for (int k = 0; k < 65535; k++) begin
      in_sel = 3'(k);
      @(posedge clk); #1;
    end
    check("count_ffff", 32'(in_count), 32'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("count_wrap", 32'(in_count), 32'h0001);
    // Spurious ready on idle channels changes nothing.
    repeat (3) @(posedge clk);
    #1;
    check("spurious_count", 32'(in_count), 32'h0001);
    check("spurious_valid", 32'(out_valid), 32'h0);
    check("spurious_ready", 32'(in_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
